voice_mixer_norm: RTL and testbench

Parametrised successor to the fixed 13-voice 8-bit mixer. On each sample strobe it captures NUM_VOICES unsigned voice samples, sums them, and counts non-zero voices. It then normalises the sum by either dividing by the active count with an internal radix-2 restoring divider or by saturating. It sits between the oscillator/envelope bank and the PWM/DAC output stage and reports result-valid and overrun status.

---
 rtl/voice_mixer_pkg.sv | 25 ++
 rtl/voice_mixer_norm_divider.sv | 63 ++++++
 rtl/voice_mixer_norm.sv | 118 +++++++++++
 tb/tb_voice_mixer_norm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/voice_mixer_pkg.sv
// Shared types and width helpers for the normalising voice mixer.
package voice_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } mixer_state_t;

  localparam int NORM_DIVIDE   = 0;
  localparam int NORM_SATURATE = 1;

  function automatic int cnt_width(input int num_voices);
    return $clog2(num_voices + 1);
  endfunction

  function automatic int sum_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices);
  endfunction

  function automatic int iter_width(input int sum_w);
    return (sum_w > 2) ? $clog2(sum_w) : 1;
  endfunction

endpackage

// File: rtl/voice_mixer_norm_divider.sv
// Radix-2 restoring divider: loads on start, produces one quotient bit per cycle MSB first.
module restoring_divider
  import voice_mixer_pkg::*;
#(
  parameter int SUM_W = 12,
  parameter int CNT_W = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [OUT_W-1:0] quotient
);

  localparam int IT_W = iter_width(SUM_W);

  logic [SUM_W-1:0] q_reg;
  logic [CNT_W-1:0] rem_reg;
  logic [CNT_W-1:0] div_reg;
  logic [IT_W-1:0]  iter_reg;
  logic             running_reg;

  logic [CNT_W:0]   trial;
  logic             take;
  logic [CNT_W-1:0] diff;

  // Partial remainder is always below the divisor, so the difference fits CNT_W bits.
  assign trial = {rem_reg, q_reg[SUM_W-1]};
  assign take  = (trial >= {1'b0, div_reg});
  assign diff  = trial[CNT_W-1:0] - div_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg       <= '0;
      rem_reg     <= '0;
      div_reg     <= '0;
      iter_reg    <= '0;
      running_reg <= 1'b0;
    end else if (start) begin
      q_reg       <= dividend;
      rem_reg     <= '0;
      div_reg     <= divisor;
      iter_reg    <= IT_W'(SUM_W - 1);
      running_reg <= 1'b1;
    end else if (running_reg) begin
      q_reg   <= {q_reg[SUM_W-2:0], take};
      rem_reg <= take ? diff : trial[CNT_W-1:0];
      if (iter_reg == '0) begin
        running_reg <= 1'b0;
      end else begin
        iter_reg <= iter_reg - 1'b1;
      end
    end
  end

  // High during the final iteration; quotient is complete after that edge.
  assign done     = running_reg && (iter_reg == '0);
  assign quotient = q_reg[OUT_W-1:0];

endmodule

// File: rtl/voice_mixer_norm.sv
// Sums NUM_VOICES samples and normalises by active-voice count or by saturation.
// Optional VOICE_MIXER_MUTE_EN adds a per-voice mute mask sampled with the voices.
module voice_mixer_norm
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 13,
  parameter int SAMPLE_W   = 8,
  parameter int NORM_MODE  = NORM_DIVIDE
) (
  input  logic                         clk,
  input  logic                         Rst,
  input  logic                         en,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voices,
`ifdef VOICE_MIXER_MUTE_EN
  input  logic [NUM_VOICES-1:0]        voice_mute,
`endif
  output logic [SAMPLE_W-1:0]          mixed_sample,
  output logic                         sample_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CNT_W = cnt_width(NUM_VOICES);
  localparam int SUM_W = sum_width(SAMPLE_W, NUM_VOICES);

  mixer_state_t        state;
  logic [SAMPLE_W-1:0] result_reg;
  logic                use_div_reg;

  logic [SAMPLE_W-1:0] voice_eff [NUM_VOICES];
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    active;
  logic [SAMPLE_W-1:0] sat_value;
  logic                div_start;
  logic                div_done;
  logic [SAMPLE_W-1:0] div_quotient;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
`ifdef VOICE_MIXER_MUTE_EN
    assign voice_eff[gi] = voice_mute[gi] ? '0 : voices[gi*SAMPLE_W +: SAMPLE_W];
`else
    assign voice_eff[gi] = voices[gi*SAMPLE_W +: SAMPLE_W];
`endif
  end

  always_comb begin
    sum    = '0;
    active = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum    = sum + SUM_W'(voice_eff[i]);
      active = active + CNT_W'(voice_eff[i] != '0);
    end
  end

  assign sat_value = (|sum[SUM_W-1:SAMPLE_W]) ? '1 : sum[SAMPLE_W-1:0];
  assign div_start = (state == IDLE) && en && (NORM_MODE == NORM_DIVIDE)
                     && (active > CNT_W'(1));

  restoring_divider #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W),
    .OUT_W(SAMPLE_W)
  ) u_divider (
    .clk     (clk),
    .rst     (Rst),
    .start   (div_start),
    .dividend(sum),
    .divisor (active),
    .done    (div_done),
    .quotient(div_quotient)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      result_reg   <= '0;
      use_div_reg  <= 1'b0;
      mixed_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            use_div_reg <= 1'b0;
            state       <= DONE;
            if (NORM_MODE == NORM_SATURATE) begin
              result_reg <= sat_value;
            end else if (active == '0) begin
              result_reg <= '0;
            end else if (active == CNT_W'(1)) begin
              // A single active voice cannot exceed SAMPLE_W bits.
              result_reg <= sum[SAMPLE_W-1:0];
            end else begin
              use_div_reg <= 1'b1;
              state       <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (en) overrun <= 1'b1;
          if (div_done) state <= DONE;
        end
        DONE: begin
          if (en) overrun <= 1'b1;
          mixed_sample <= use_div_reg ? div_quotient : result_reg;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_voice_mixer_norm.sv
// Self-checking bench: divide-mode and saturate-mode mixers against a behavioural model.
module tb_voice_mixer_norm;

  localparam int NV    = 13;
  localparam int SW    = 8;
  localparam int SUMW  = SW + $clog2(NV);
  localparam int MAXV  = (1 << SW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [NV*SW-1:0] voices = '0;
  logic [NV-1:0]    mute = '0;
  logic             checking = 1'b0;

  logic [SW-1:0] ms0, ms1;
  logic          sv0, sv1, bz0, bz1, ov0, ov1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  voice_mixer_norm #(.NUM_VOICES(NV), .SAMPLE_W(SW), .NORM_MODE(0)) dut_div (
    .clk(clk), .Rst(rst), .en(en), .voices(voices),
`ifdef VOICE_MIXER_MUTE_EN
    .voice_mute(mute),
`endif
    .mixed_sample(ms0), .sample_valid(sv0), .busy(bz0), .overrun(ov0)
  );

  voice_mixer_norm #(.NUM_VOICES(NV), .SAMPLE_W(SW), .NORM_MODE(1)) dut_sat (
    .clk(clk), .Rst(rst), .en(en), .voices(voices),
`ifdef VOICE_MIXER_MUTE_EN
    .voice_mute(mute),
`endif
    .mixed_sample(ms1), .sample_valid(sv1), .busy(bz1), .overrun(ov1)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the mixing rules.
  function automatic int model_result(input int mode, input logic [NV*SW-1:0] v,
                                      input logic [NV-1:0] mk, output bit shortcut);
    int s = 0;
    int a = 0;
    for (int i = 0; i < NV; i++) begin
      int x;
      x = mk[i] ? 0 : int'(v[i*SW +: SW]);
      s += x;
      if (x != 0) a++;
    end
    if (mode == 1) begin
      shortcut = 1'b1;
      return (s > MAXV) ? MAXV : s;
    end
    shortcut = (a < 2);
    return (a == 0) ? 0 : s / a;
  endfunction

  int busy_left [2];
  int pend [2];
  int exp_ms [2];
  bit exp_sv [2];
  bit exp_ov [2];

  always @(posedge clk or posedge rst) begin
    bit sc;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        busy_left[m] = 0;
        pend[m]      = 0;
        exp_ms[m]    = 0;
        exp_sv[m]    = 1'b0;
        exp_ov[m]    = 1'b0;
      end else begin
        exp_sv[m] = 1'b0;
        if (busy_left[m] > 0) begin
          if (en) exp_ov[m] = 1'b1;
          busy_left[m]--;
          if (busy_left[m] == 0) begin
            exp_ms[m] = pend[m];
            exp_sv[m] = 1'b1;
          end
        end else if (en) begin
          pend[m]      = model_result(m, voices, mute, sc);
          busy_left[m] = sc ? 1 : SUMW + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("div_mixed_sample", int'(ms0), exp_ms[0]);
      check("div_sample_valid", int'(sv0), int'(exp_sv[0]));
      check("div_busy", int'(bz0), int'(busy_left[0] > 0));
      check("div_overrun", int'(ov0), int'(exp_ov[0]));
      check("sat_mixed_sample", int'(ms1), exp_ms[1]);
      check("sat_sample_valid", int'(sv1), int'(exp_sv[1]));
      check("sat_busy", int'(bz1), int'(busy_left[1] > 0));
      check("sat_overrun", int'(ov1), int'(exp_ov[1]));
    end
  end

  task automatic run_one(input string name, input logic [NV*SW-1:0] v,
                         input int e0, input int lat0, input int e1);
    int n;
    int bc;
    voices = v;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n  = 0;
    bc = bz0 ? 1 : 0;
    while (!sv0 && n < 40) begin
      @(negedge clk);
      n++;
      if (bz0) bc++;
    end
    check({name, "_latency"}, n, lat0);
    check({name, "_busy_cycles"}, bc, lat0);
    check({name, "_div_result"}, int'(ms0), e0);
    check({name, "_sat_result"}, int'(ms1), e1);
    $display("txn %s: div=%0d sat=%0d latency=%0d", name, ms0, ms1, n);
    @(negedge clk);
  endtask

  initial begin
    logic [NV*SW-1:0] t;
    int n;

    #1 rst = 1'b1;
    #1 checking = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    t = '1;
    run_one("all_255", t, 255, SUMW + 1, 255);

    t = '0; t[0*SW +: SW] = 8'd100; t[1*SW +: SW] = 8'd50; t[2*SW +: SW] = 8'd30;
    run_one("three_voice", t, 60, SUMW + 1, 180);

    t = '0; t[7*SW +: SW] = 8'd255; t[8*SW +: SW] = 8'd0;
    run_one("single_active", t, 255, 1, 255);

    t = '0;
    run_one("all_zero", t, 0, 1, 0);

    t = '0; t[0*SW +: SW] = 8'd200; t[1*SW +: SW] = 8'd100;
    run_one("sat_200_100", t, 150, SUMW + 1, 255);

    t = '0; t[0*SW +: SW] = 8'd20; t[1*SW +: SW] = 8'd30;
    run_one("sat_20_30", t, 25, SUMW + 1, 50);

    // Second strobe lands mid-divide: divider ignores it, saturator accepts it.
    t = '0; t[0*SW +: SW] = 8'd100; t[1*SW +: SW] = 8'd50; t[2*SW +: SW] = 8'd30;
    voices = t; en = 1'b1; @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1; @(negedge clk); en = 1'b0;
    check("overrun_set", int'(ov0), 1);
    check("overrun_sat_idle", int'(ov1), 0);
    n = 0;
    while (!sv0 && n < 40) begin @(negedge clk); n++; end
    check("overrun_first_result", int'(ms0), 60);
    repeat (20) @(negedge clk);
    check("overrun_sticky", int'(ov0), 1);
    $display("txn overrun: div=%0d overrun=%0d", ms0, ov0);

    // Asynchronous reset in the middle of a division.
    t = '1;
    voices = t; en = 1'b1; @(negedge clk); en = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mixed_sample", int'(ms0), 0);
    check("rst_sample_valid", int'(sv0), 0);
    check("rst_busy", int'(bz0), 0);
    check("rst_overrun", int'(ov0), 0);
    $display("txn async_reset: busy=%0d overrun=%0d", bz0, ov0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    t = '0; t[0*SW +: SW] = 8'd90; t[1*SW +: SW] = 8'd30;
    run_one("after_reset", t, 60, SUMW + 1, 120);

`ifdef VOICE_MIXER_MUTE_EN
    t = '0; t[0*SW +: SW] = 8'd100; t[1*SW +: SW] = 8'd50; t[2*SW +: SW] = 8'd30;
    mute = '0; mute[2] = 1'b1;
    run_one("mute_voice2", t, 75, SUMW + 1, 150);
    mute = '0;
`endif

    // Randomised traffic, including strobes while busy and inputs changing mid-divide.
    for (int i = 0; i < 600; i++) begin
      int dens;
      dens = $urandom_range(4);
      for (int k = 0; k < NV; k++) begin
        t[k*SW +: SW] = ($urandom_range(3) < dens) ? SW'($urandom) : '0;
      end
      voices = t;
`ifdef VOICE_MIXER_MUTE_EN
      mute = NV'($urandom);
`endif
      en = ($urandom_range(5) == 0);
      @(negedge clk);
      if (sv0) $display("txn random: div=%0d at %0t", ms0, $time);
    end
    en = 1'b0;
    repeat (SUMW + 4) @(negedge clk);
    check("final_idle", int'(bz0 | bz1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
